// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared types and helpers for the 16-way round-robin one-hot arbiter.
package rr_onehot_arbiter_pkg;

   localparam int unsigned NUM_REQ = 16;
   localparam int unsigned ID_W    = 4;

   // Arbiter control states.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StGrant = 2'd1,
      StGap   = 2'd2
   } state_e;

   // Binary index to 16-bit one-hot vector.
   function automatic logic [NUM_REQ-1:0] onehot16(input logic [ID_W-1:0] id);
      logic [NUM_REQ-1:0] oh;
      oh     = '0;
      oh[id] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/onehot_dec16.sv
// Combinational 4-to-16 binary-to-one-hot decoder with enable.
// Produces all zeros when disabled so the grant register can never hold a stale bit.
module onehot_dec16
   import rr_onehot_arbiter_pkg::*;
(
   input  logic [ID_W-1:0]    id_i,
   input  logic               en_i,
   output logic [NUM_REQ-1:0] onehot_o
);

   // Decode the index, gated by the enable.
   always_comb begin
      onehot_o = '0;
      if (en_i) begin
         onehot_o = onehot16(id_i);
      end
   end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter sharing one resource among 16 requesters.
// Registered one-hot grant plus binary index, a bounded hold time with a
// timeout pulse on forced revoke, and one idle cycle between any two grants.
module rr_onehot_arbiter
   import rr_onehot_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 15,
   parameter int unsigned CNT_W    = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_id,
   output logic               gnt_valid,
   output logic               timeout
);

   state_e             state_q, state_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
   logic               gnt_valid_q, gnt_valid_d;
   logic               timeout_q, timeout_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;

   // Winner search signals.
   logic [ID_W-1:0]      search_base;
   logic [2*NUM_REQ-1:0] req_dbl;
   logic [NUM_REQ-1:0]   req_rot;
   logic [ID_W-1:0]      rot_idx;
   logic [ID_W-1:0]      winner;
   logic                 req_any;

   // Rotate req so bit 0 is the requester just after ptr, priority-encode, then un-rotate.
   always_comb begin
      search_base = ptr_q + ID_W'(1);
      req_dbl     = {req, req};
      req_rot     = req_dbl[search_base +: NUM_REQ];
      rot_idx     = '0;
      // Scan downward so the lowest set bit wins.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            rot_idx = ID_W'(i);
         end
      end
      winner  = search_base + rot_idx;
      req_any = |req;
   end

   // Next-state logic: grant, hold and revoke decisions.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      hold_cnt_d  = hold_cnt_q;
      gnt_id_d    = gnt_id_q;
      gnt_valid_d = gnt_valid_q;
      timeout_d   = 1'b0;

      unique case (state_q)
         StIdle, StGap: begin
            if (req_any) begin
               state_d     = StGrant;
               gnt_id_d    = winner;
               ptr_d       = winner;
               hold_cnt_d  = CNT_W'(1);
               gnt_valid_d = 1'b1;
            end else begin
               state_d = StIdle;
            end
         end
         StGrant: begin
            // A voluntary release takes precedence over the hold limit.
            if (!req[gnt_id_q]) begin
               state_d     = StGap;
               gnt_valid_d = 1'b0;
            end else if (hold_cnt_q == CNT_W'(MAX_HOLD)) begin
               state_d     = StGap;
               gnt_valid_d = 1'b0;
               timeout_d   = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d     = StIdle;
            gnt_valid_d = 1'b0;
         end
      endcase
   end

   // The grant vector is derived from the next index so it always matches gnt_id.
   onehot_dec16 u_dec (
      .id_i     (gnt_id_d),
      .en_i     (gnt_valid_d),
      .onehot_o (gnt_d)
   );

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         ptr_q       <= ID_W'(NUM_REQ - 1);
         hold_cnt_q  <= '0;
         gnt_id_q    <= '0;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         gnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         hold_cnt_q  <= hold_cnt_d;
         gnt_id_q    <= gnt_id_d;
         gnt_valid_q <= gnt_valid_d;
         timeout_q   <= timeout_d;
         gnt_q       <= gnt_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_id    = gnt_id_q;
   assign gnt_valid = gnt_valid_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Bench for rr_onehot_arbiter: one instance with MAX_HOLD=15 (a) and one with MAX_HOLD=2 (b),
// directed vector table, hand sequences and a random run checked against a reference model.
module tb_rr_onehot_arbiter;

   localparam int HOLD_A  = 15;
   localparam int HOLD_B  = 2;
   localparam int BOUND_A = 16 * (HOLD_A + 1);
   localparam int BOUND_B = 16 * (HOLD_B + 1);
   localparam int M_IDLE  = 0;
   localparam int M_GRANT = 1;
   localparam int M_GAP   = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] req_a = '0, req_b = '0;
   logic [15:0] gnt_a, gnt_b;
   logic [3:0]  id_a, id_b;
   logic        v_a, v_b, to_a, to_b;

   always #5 clk = ~clk;

   rr_onehot_arbiter #(.MAX_HOLD(HOLD_A), .CNT_W(8)) u_dut_a (
      .clk       (clk),
      .rst       (rst),
      .req       (req_a),
      .gnt       (gnt_a),
      .gnt_id    (id_a),
      .gnt_valid (v_a),
      .timeout   (to_a)
   );

   rr_onehot_arbiter #(.MAX_HOLD(HOLD_B), .CNT_W(8)) u_dut_b (
      .clk       (clk),
      .rst       (rst),
      .req       (req_b),
      .gnt       (gnt_b),
      .gnt_id    (id_b),
      .gnt_valid (v_b),
      .timeout   (to_b)
   );

   typedef struct packed {
      logic [1:0] st;
      logic [3:0] ptr;
      logic [7:0] cnt;
      logic [3:0] id;
      logic       valid;
      logic       to;
   } mdl_t;

   typedef struct packed {
      logic [15:0] gnt;
      logic [3:0]  id;
      logic        v;
      logic        to;
   } exp_t;

   typedef struct {
      logic        rst;
      logic        sel;   // 0: dut a, 1: dut b
      logic [15:0] req;
      logic [15:0] gnt;
      logic [3:0]  id;
      logic        v;
      logic        to;
   } vec_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   mdl_t m_a, m_b;
   exp_t q_a[$], q_b[$];
   vec_t tbl[$];
   int   run_a = 0, run_b = 0;
   logic prev_v_a = 1'b0, prev_v_b = 1'b0;
   logic [3:0] prev_id_a = '0, prev_id_b = '0;
   int   wait_a[16], wait_b[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
      n_checks++;
      if (act !== req_v) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req_v, $time);
      end
   endtask

   function automatic mdl_t mreset();
      mdl_t n;
      n     = '0;
      n.ptr = 4'd15;
      return n;
   endfunction

   // Reference behaviour: state after one clock edge.
   function automatic mdl_t mstep(mdl_t m, int maxh, logic r, logic [15:0] rq);
      mdl_t n;
      logic found;
      int   w;
      if (r) return mreset();
      n    = m;
      n.to = 1'b0;
      if (int'(m.st) == M_GRANT) begin
         if (!rq[m.id]) begin
            n.st    = 2'(M_GAP);
            n.valid = 1'b0;
         end else if (int'(m.cnt) == maxh) begin
            n.st    = 2'(M_GAP);
            n.valid = 1'b0;
            n.to    = 1'b1;
         end else begin
            n.cnt = m.cnt + 8'd1;
         end
      end else begin
         found = 1'b0;
         w     = 0;
         for (int k = 1; k <= 16; k++) begin
            if (!found && rq[(int'(m.ptr) + k) % 16]) begin
               found = 1'b1;
               w     = (int'(m.ptr) + k) % 16;
            end
         end
         if (found) begin
            n.st    = 2'(M_GRANT);
            n.id    = 4'(w);
            n.ptr   = 4'(w);
            n.cnt   = 8'd1;
            n.valid = 1'b1;
         end else begin
            n.st = 2'(M_IDLE);
         end
      end
      return n;
   endfunction

   function automatic exp_t mexp(mdl_t m);
      exp_t e;
      e.gnt = m.valid ? (16'h1 << m.id) : 16'h0;
      e.id  = m.id;
      e.v   = m.valid;
      e.to  = m.to;
      return e;
   endfunction

   task automatic add(input logic r, input logic s, input logic [15:0] rq, input logic [15:0] g,
                      input int id, input logic v, input logic to);
      vec_t x;
      x.rst = r; x.sel = s; x.req = rq; x.gnt = g; x.id = 4'(id); x.v = v; x.to = to;
      tbl.push_back(x);
   endtask

   // One clock: drive at negedge, queue expectations, compare 1 time unit after posedge.
   task automatic cycle(input logic r, input logic [15:0] ra, input logic [15:0] rb);
      exp_t ea, eb;
      int   worst_a, worst_b;
      @(negedge clk);
      rst   = r;
      req_a = ra;
      req_b = rb;
      m_a   = mstep(m_a, HOLD_A, r, ra);
      m_b   = mstep(m_b, HOLD_B, r, rb);
      q_a.push_back(mexp(m_a));
      q_b.push_back(mexp(m_b));
      @(posedge clk);
      #1;
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      chk("sb_a_gnt", 32'(gnt_a), 32'(ea.gnt));
      chk("sb_a_id",  32'(id_a),  32'(ea.id));
      chk("sb_a_valid", 32'(v_a), 32'(ea.v));
      chk("sb_a_timeout", 32'(to_a), 32'(ea.to));
      chk("sb_b_gnt", 32'(gnt_b), 32'(eb.gnt));
      chk("sb_b_id",  32'(id_b),  32'(eb.id));
      chk("sb_b_valid", 32'(v_b), 32'(eb.v));
      chk("sb_b_timeout", 32'(to_b), 32'(eb.to));
      chk("onehot_a", 32'($onehot0(gnt_a)), 32'd1);
      chk("onehot_b", 32'($onehot0(gnt_b)), 32'd1);
      chk("gnt_vs_id_a", 32'(gnt_a), v_a ? 32'(16'h1 << id_a) : 32'd0);
      chk("gnt_vs_id_b", 32'(gnt_b), v_b ? 32'(16'h1 << id_b) : 32'd0);
      run_a = !v_a ? 0 : ((prev_v_a && id_a == prev_id_a) ? run_a + 1 : 1);
      run_b = !v_b ? 0 : ((prev_v_b && id_b == prev_id_b) ? run_b + 1 : 1);
      prev_v_a = v_a; prev_id_a = id_a;
      prev_v_b = v_b; prev_id_b = id_b;
      chk("hold_a", 32'(run_a <= HOLD_A), 32'd1);
      chk("hold_b", 32'(run_b <= HOLD_B), 32'd1);
      worst_a = 0;
      worst_b = 0;
      for (int j = 0; j < 16; j++) begin
         wait_a[j] = (r || !ra[j] || gnt_a[j]) ? 0 : wait_a[j] + 1;
         wait_b[j] = (r || !rb[j] || gnt_b[j]) ? 0 : wait_b[j] + 1;
         if (wait_a[j] > worst_a) worst_a = wait_a[j];
         if (wait_b[j] > worst_b) worst_b = wait_b[j];
      end
      chk("latency_a", 32'(worst_a <= BOUND_A), 32'd1);
      chk("latency_b", 32'(worst_b <= BOUND_B), 32'd1);
   endtask

   initial begin
      logic [15:0] ra, rb;
      logic        r;
      m_a = mreset();
      m_b = mreset();
      for (int j = 0; j < 16; j++) begin
         wait_a[j] = 0;
         wait_b[j] = 0;
      end

      // All requesters on, MAX_HOLD=2: 0,1,...,15,0 each for 2 cycles, timeout gap after each.
      add(1, 1, 16'h0000, 16'h0000, 0, 0, 0);
      for (int g = 0; g <= 16; g++) begin
         add(0, 1, 16'hFFFF, 16'h1 << (g % 16), g % 16, 1, 0);
         add(0, 1, 16'hFFFF, 16'h1 << (g % 16), g % 16, 1, 0);
         add(0, 1, 16'hFFFF, 16'h0000, g % 16, 0, 1);
      end
      // Wrap-around from ptr=5 to requester 0, then back to 5.
      add(1, 1, 16'h0000, 16'h0000, 0, 0, 0);
      add(0, 1, 16'h0020, 16'h0020, 5, 1, 0);
      add(0, 1, 16'h0021, 16'h0020, 5, 1, 0);
      add(0, 1, 16'h0021, 16'h0000, 5, 0, 1);
      add(0, 1, 16'h0021, 16'h0001, 0, 1, 0);
      add(0, 1, 16'h0021, 16'h0001, 0, 1, 0);
      add(0, 1, 16'h0020, 16'h0000, 0, 0, 0);
      add(0, 1, 16'h0020, 16'h0020, 5, 1, 0);
      add(0, 1, 16'h0000, 16'h0000, 5, 0, 0);
      add(0, 1, 16'h0000, 16'h0000, 5, 0, 0);
      // Requester 3 releases after 4 cycles with 9 pending: no timeout, one gap, then 9.
      add(1, 0, 16'h0000, 16'h0000, 0, 0, 0);
      add(0, 0, 16'h0008, 16'h0008, 3, 1, 0);
      add(0, 0, 16'h0208, 16'h0008, 3, 1, 0);
      add(0, 0, 16'h0208, 16'h0008, 3, 1, 0);
      add(0, 0, 16'h0208, 16'h0008, 3, 1, 0);
      add(0, 0, 16'h0200, 16'h0000, 3, 0, 0);
      add(0, 0, 16'h0200, 16'h0200, 9, 1, 0);
      add(0, 0, 16'h0000, 16'h0000, 9, 0, 0);
      // Reset mid-grant to 7; afterwards the search restarts at 0 so 7 beats 11.
      add(0, 0, 16'h0080, 16'h0080, 7, 1, 0);
      add(0, 0, 16'h0080, 16'h0080, 7, 1, 0);
      add(1, 0, 16'h0080, 16'h0000, 0, 0, 0);
      add(0, 0, 16'h0880, 16'h0080, 7, 1, 0);
      add(0, 0, 16'h0800, 16'h0000, 7, 0, 0);
      add(0, 0, 16'h0800, 16'h0800, 11, 1, 0);

      foreach (tbl[i]) begin
         cycle(tbl[i].rst, tbl[i].sel ? 16'h0 : tbl[i].req, tbl[i].sel ? tbl[i].req : 16'h0);
         chk($sformatf("vec%0d_gnt", i), 32'(tbl[i].sel ? gnt_b : gnt_a), 32'(tbl[i].gnt));
         chk($sformatf("vec%0d_id", i), 32'(tbl[i].sel ? id_b : id_a), 32'(tbl[i].id));
         chk($sformatf("vec%0d_valid", i), 32'(tbl[i].sel ? v_b : v_a), 32'(tbl[i].v));
         chk($sformatf("vec%0d_timeout", i), 32'(tbl[i].sel ? to_b : to_a), 32'(tbl[i].to));
      end

      // Sole requester 0 with MAX_HOLD=15: 15 grant cycles, timeout gap, re-grant.
      cycle(1'b1, 16'h0, 16'h0);
      for (int i = 1; i <= 15; i++) begin
         cycle(1'b0, 16'h0001, 16'h0);
         chk($sformatf("solo_gnt%0d", i), 32'(gnt_a), 32'h0001);
         chk($sformatf("solo_to%0d", i), 32'(to_a), 32'd0);
      end
      cycle(1'b0, 16'h0001, 16'h0);
      chk("solo_gap_gnt", 32'(gnt_a), 32'h0);
      chk("solo_gap_valid", 32'(v_a), 32'd0);
      chk("solo_gap_to", 32'(to_a), 32'd1);
      cycle(1'b0, 16'h0001, 16'h0);
      chk("solo_regrant_gnt", 32'(gnt_a), 32'h0001);
      chk("solo_regrant_id", 32'(id_a), 32'd0);
      chk("solo_regrant_to", 32'(to_a), 32'd0);

      // Random traffic: each request bit toggles occasionally, rare resets.
      cycle(1'b1, 16'h0, 16'h0);
      ra = '0;
      rb = '0;
      for (int c = 0; c < 10000; c++) begin
         for (int j = 0; j < 16; j++) begin
            if ($urandom_range(0, 7) == 0) ra[j] = ~ra[j];
            if ($urandom_range(0, 7) == 0) rb[j] = ~rb[j];
         end
         r = ($urandom_range(0, 999) == 0);
         cycle(r, ra, rb);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
